// File: rtl/mux8_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux8_bus_arbiter
// Brief    : Round-robin arbiter owning the select of an 8:1 data mux, with a
//            valid/ready output and grants held for up to MAX_HOLD transfers.
// Revision : 1.0  initial release
// ============================================================================

module mux8_bus_arbiter_mux #(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    case (sel)
      3'd0: y = a;
      3'd1: y = b;
      3'd2: y = c;
      3'd3: y = d;
      3'd4: y = e;
      3'd5: y = f;
      3'd6: y = g;
      3'd7: y = h;
    endcase
  end

endmodule

module mux8_bus_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic             ready,
  output logic [7:0]       grant,
  output logic [2:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             busy
);

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_grant = 1'b1;
  localparam logic [3:0] c_max_hold = 4'(MAX_HOLD);

  logic [0:0] r_state, w_state_nxt;
  logic [2:0] r_sel, w_sel_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic [3:0] r_count, w_count_nxt;
  logic [2:0] w_winner;
  logic       w_owner_req;
  logic       w_xfer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Scan from the farthest offset back to ptr so the nearest set bit wins.
  always_comb begin
    w_winner = r_ptr;
    for (int i = 7; i >= 0; i--) begin
      if (req[r_ptr + 3'(i)]) w_winner = r_ptr + 3'(i);
    end
  end

  assign w_owner_req = req[r_sel];
  assign w_xfer      = valid & ready;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    case (r_state)
      c_st_idle: begin
        if (|req) begin
          w_state_nxt = c_st_grant;
          w_sel_nxt   = w_winner;
          w_count_nxt = '0;
        end
      end
      c_st_grant: begin
        if (!w_owner_req || (w_xfer && (r_count + 4'd1 == c_max_hold))) begin
          w_state_nxt = c_st_idle;
          w_ptr_nxt   = r_sel + 3'd1;
          w_count_nxt = '0;
        end else if (w_xfer) begin
          w_count_nxt = r_count + 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    grant = '0;
    valid = 1'b0;
    busy  = 1'b0;
    if (r_state == c_st_grant) begin
      grant = 8'b1 << r_sel;
      valid = w_owner_req;
      busy  = 1'b1;
    end
  end

  assign sel = r_sel;

  mux8_bus_arbiter_mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel (r_sel),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .e   (e),
    .f   (f),
    .g   (g),
    .h   (h),
    .y   (out)
  );

endmodule

`default_nettype wire
